// File: rtl/ram_dp_if.sv
// Bus bundle between the fetch/LSU side (master) and the dual-port RAM (slave).
// Port A is a read-only fetch port; port B is a byte-strobed load/store port.
interface ram_dp_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    a_rd_en;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_rd_data;
  logic                    a_rd_valid;

  logic                    b_rd_en;
  logic                    b_wr_en;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic [DATA_WIDTH-1:0]   b_wr_data;
  logic [DATA_WIDTH/8-1:0] b_wr_strobe;
  logic [DATA_WIDTH-1:0]   b_rd_data;
  logic                    b_rd_valid;

  modport master (
    output a_rd_en, a_addr,
    input  a_rd_data, a_rd_valid,
    output b_rd_en, b_wr_en, b_addr, b_wr_data, b_wr_strobe,
    input  b_rd_data, b_rd_valid
  );

  modport slave (
    input  a_rd_en, a_addr,
    output a_rd_data, a_rd_valid,
    input  b_rd_en, b_wr_en, b_addr, b_wr_data, b_wr_strobe,
    output b_rd_data, b_rd_valid
  );
endinterface

// File: rtl/ram_dp.sv
// True-dual-port word RAM: port A fetch reads, port B byte-strobed load/store.
// Synchronous reads with a 1- or 2-stage pipeline and a selectable collision policy.
module ram_dp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int WRITE_MODE = 0,
  parameter int DUMP_MEM   = 0
) (
  input logic     clk,
  input logic     rst,
  ram_dp_if.slave bus
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam bit BYPASS    = (WRITE_MODE == 1);

  generate
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("ram_dp: DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
      $error("ram_dp: RD_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE != 0 && WRITE_MODE != 1) begin : g_bad_write_mode
      $error("ram_dp: WRITE_MODE must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] a_old;
  logic [DATA_WIDTH-1:0] b_old;
  logic [DATA_WIDTH-1:0] b_wr_mask;
  logic [DATA_WIDTH-1:0] b_merged;
  logic                  do_write;
  logic                  a_collide;
  logic [DATA_WIDTH-1:0] a_fetch;
  logic [DATA_WIDTH-1:0] b_fetch;

  logic                  a_s1_valid;
  logic [DATA_WIDTH-1:0] a_s1_data;
  logic                  b_s1_valid;
  logic [DATA_WIDTH-1:0] b_s1_data;

  assign a_old = mem[bus.a_addr];
  assign b_old = mem[bus.b_addr];

  always_comb begin
    b_wr_mask = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      b_wr_mask[8*k +: 8] = {8{bus.b_wr_strobe[k]}};
    end
  end

  // The merged word is both what gets stored and what write-first readers see.
  assign b_merged  = (b_old & ~b_wr_mask) | (bus.b_wr_data & b_wr_mask);
  assign do_write  = bus.b_wr_en && !rst;
  assign a_collide = bus.b_wr_en && (bus.a_addr == bus.b_addr);

  assign a_fetch = (BYPASS && a_collide)   ? b_merged : a_old;
  assign b_fetch = (BYPASS && bus.b_wr_en) ? b_merged : b_old;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[bus.b_addr] <= b_merged;
    end
  end

  // First read stage; data registers only load on a request so they hold the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1_valid <= 1'b0;
      a_s1_data  <= '0;
      b_s1_valid <= 1'b0;
      b_s1_data  <= '0;
    end else begin
      a_s1_valid <= bus.a_rd_en;
      b_s1_valid <= bus.b_rd_en;
      if (bus.a_rd_en) begin
        a_s1_data <= a_fetch;
      end
      if (bus.b_rd_en) begin
        b_s1_data <= b_fetch;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_out_reg
      logic                  a_s2_valid;
      logic [DATA_WIDTH-1:0] a_s2_data;
      logic                  b_s2_valid;
      logic [DATA_WIDTH-1:0] b_s2_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_s2_valid <= 1'b0;
          a_s2_data  <= '0;
          b_s2_valid <= 1'b0;
          b_s2_data  <= '0;
        end else begin
          a_s2_valid <= a_s1_valid;
          b_s2_valid <= b_s1_valid;
          if (a_s1_valid) begin
            a_s2_data <= a_s1_data;
          end
          if (b_s1_valid) begin
            b_s2_data <= b_s1_data;
          end
        end
      end

      assign bus.a_rd_valid = a_s2_valid;
      assign bus.a_rd_data  = a_s2_data;
      assign bus.b_rd_valid = b_s2_valid;
      assign bus.b_rd_data  = b_s2_data;
    end else begin : g_no_out_reg
      assign bus.a_rd_valid = a_s1_valid;
      assign bus.a_rd_data  = a_s1_data;
      assign bus.b_rd_valid = b_s1_valid;
      assign bus.b_rd_data  = b_s1_data;
    end
  endgenerate

  generate
    if (DUMP_MEM == 1) begin : g_dump
      for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_WIDTH-1:0] word;
        assign word = mem[i];
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Scoreboard bench for ram_dp: two instances (1-cycle read-first, 2-cycle write-first)
// share one stimulus stream and one word-level memory model.
module tb_ram_dp;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  ram_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  ram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .WRITE_MODE(0), .DUMP_MEM(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .WRITE_MODE(1), .DUMP_MEM(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa0[$];
  exp_t qb0[$];
  exp_t qa1[$];
  exp_t qb1[$];

  logic [31:0] model [256];
  logic [31:0] last_out [4];
  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic a_en, input logic [7:0] a_ad,
                               input logic b_rd, input logic b_wr, input logic [7:0] b_ad,
                               input logic [31:0] b_dat, input logic [3:0] b_strb);
    logic [31:0] old_a;
    logic [31:0] old_b;
    logic [31:0] merged;
    @(negedge clk);
    #1;
    bus0.a_rd_en = a_en; bus0.a_addr = a_ad; bus0.b_rd_en = b_rd; bus0.b_wr_en = b_wr;
    bus0.b_addr = b_ad; bus0.b_wr_data = b_dat; bus0.b_wr_strobe = b_strb;
    bus1.a_rd_en = a_en; bus1.a_addr = a_ad; bus1.b_rd_en = b_rd; bus1.b_wr_en = b_wr;
    bus1.b_addr = b_ad; bus1.b_wr_data = b_dat; bus1.b_wr_strobe = b_strb;
    if (!rst) begin
      old_a  = model[a_ad];
      old_b  = model[b_ad];
      merged = old_b;
      if (b_wr) begin
        for (int k = 0; k < 4; k++) begin
          if (b_strb[k]) merged[8*k +: 8] = b_dat[8*k +: 8];
        end
      end
      if (a_en) begin
        qa0.push_back(exp_t'{data: old_a, due: cyc + 1});
        qa1.push_back(exp_t'{data: (b_wr && a_ad == b_ad) ? merged : old_a, due: cyc + 2});
      end
      if (b_rd) begin
        qb0.push_back(exp_t'{data: old_b, due: cyc + 1});
        qb1.push_back(exp_t'{data: b_wr ? merged : old_b, due: cyc + 2});
      end
      if (b_wr) model[b_ad] = merged;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
  endtask

  function automatic int q_size(input int p);
    case (p)
      0:       return qa0.size();
      1:       return qb0.size();
      2:       return qa1.size();
      default: return qb1.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int p);
    case (p)
      0:       return qa0[0];
      1:       return qb0[0];
      2:       return qa1[0];
      default: return qb1[0];
    endcase
  endfunction

  function automatic exp_t q_pop(input int p);
    case (p)
      0:       return qa0.pop_front();
      1:       return qb0.pop_front();
      2:       return qa1.pop_front();
      default: return qb1.pop_front();
    endcase
  endfunction

  // Pops on every valid pulse; a due entry with no pulse, or a pulse with nothing due, fails.
  task automatic monitor_port(input int p, input string name, input logic v, input logic [31:0] d);
    exp_t e;
    if (rst) begin
      checkOutput({name, " reset valid"}, {31'd0, v}, 32'd0);
      checkOutput({name, " reset data"}, d, 32'd0);
      last_out[p] = 32'd0;
    end else if (v) begin
      if (q_size(p) == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s spurious valid: got data %h, expected no pulse (cycle %0d)", name, d, cyc);
      end else begin
        e = q_pop(p);
        checkOutput({name, " data"}, d, e.data);
        checkOutput({name, " arrival cycle"}, 32'(cyc), 32'(e.due));
        last_out[p] = e.data;
      end
    end else begin
      checkOutput({name, " hold data"}, d, last_out[p]);
      if (q_size(p) != 0 && q_front(p).due <= cyc) begin
        e = q_pop(p);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s missing valid: got valid 0, expected %h due at cycle %0d", name, e.data, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_port(0, "a0", bus0.a_rd_valid, bus0.a_rd_data);
    monitor_port(1, "b0", bus0.b_rd_valid, bus0.b_rd_data);
    monitor_port(2, "a1", bus1.a_rd_valid, bus1.a_rd_data);
    monitor_port(3, "b1", bus1.b_rd_valid, bus1.b_rd_data);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus0.a_rd_en = 1'b0; bus0.a_addr = '0; bus0.b_rd_en = 1'b0; bus0.b_wr_en = 1'b0;
    bus0.b_addr = '0; bus0.b_wr_data = '0; bus0.b_wr_strobe = '0;
    bus1.a_rd_en = 1'b0; bus1.a_addr = '0; bus1.b_rd_en = 1'b0; bus1.b_wr_en = 1'b0;
    bus1.b_addr = '0; bus1.b_wr_data = '0; bus1.b_wr_strobe = '0;
    for (int i = 0; i < 4; i++) last_out[i] = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    $display("[TB] full write then fetch read");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 32'd0, 4'h0);
    idle_cycles(3);

    $display("[TB] partial write");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 32'h11223344, 4'hF);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 32'd0, 4'h0);
    idle_cycles(3);

    $display("[TB] cross-port collision");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 8'd7, 32'h00000000, 4'hF);
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b1, 8'd7, 32'hFFFFFFFF, 4'hF);
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b0, 8'd0, 32'd0, 4'h0);
    idle_cycles(3);

    $display("[TB] preload and back-to-back reads");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 8'(i), $urandom, 4'hF);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 8'(15 - i), 32'd0, 4'h0);
    idle_cycles(5);

    $display("[TB] port B read+write same address");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd9, 32'h5A5A5A5A, 4'h0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd9, 32'hC3C3C3C3, 4'hF);
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b0, 8'd9, 32'd0, 4'h0);
    idle_cycles(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), 8'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                    8'($urandom_range(0, 15)), $urandom, 4'($urandom));
    end
    idle_cycles(4);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 8'd3, 32'd0, 4'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("a0 async reset valid", {31'd0, bus0.a_rd_valid}, 32'd0);
    checkOutput("a0 async reset data", bus0.a_rd_data, 32'd0);
    checkOutput("b0 async reset valid", {31'd0, bus0.b_rd_valid}, 32'd0);
    checkOutput("b0 async reset data", bus0.b_rd_data, 32'd0);
    checkOutput("a1 async reset valid", {31'd0, bus1.a_rd_valid}, 32'd0);
    checkOutput("a1 async reset data", bus1.a_rd_data, 32'd0);
    checkOutput("b1 async reset valid", {31'd0, bus1.b_rd_valid}, 32'd0);
    checkOutput("b1 async reset data", bus1.b_rd_data, 32'd0);
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 32'h0BADF00D, 4'hF);
    @(posedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0, 4'h0);
    rst = 1'b0;
    idle_cycles(4);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 8'd3, 32'd0, 4'h0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 32'd0, 4'h0);
    idle_cycles(5);

    checkOutput("a0 queue drained", 32'(qa0.size()), 32'd0);
    checkOutput("b0 queue drained", 32'(qb0.size()), 32'd0);
    checkOutput("a1 queue drained", 32'(qa1.size()), 32'd0);
    checkOutput("b1 queue drained", 32'(qb1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
